// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Optional macro MEM_TIMEOUT_EN aborts a grant after TIMEOUT cycles without mem_ack.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic          mem_req_reg, mem_req_next;
  logic          mem_we_reg, mem_we_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]   mem_wdata_reg, mem_wdata_next;
  logic [31:0]   if_rdata_reg, if_rdata_next;
  logic [31:0]   d_rdata_reg, d_rdata_next;
  logic          if_ready_reg, if_ready_next;
  logic          d_ready_reg, d_ready_next;
  logic          busy_reg, busy_next;
  logic          timeout_hit;

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("mem_port_arbiter: TIMEOUT must be >= 2");
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic          err_reg, err_next;

  assign timeout_hit = (tmo_cnt_reg == CW'(TIMEOUT - 1));

  // Every grant is entered from IDLE, so clearing there restarts the count per access.
  always_comb begin
    tmo_cnt_next = tmo_cnt_reg;
    err_next     = 1'b0;
    if (state_reg == IDLE) begin
      tmo_cnt_next = '0;
    end else if ((state_reg == GNT_IF || state_reg == GNT_D) && !mem_ack) begin
      if (timeout_hit) err_next = 1'b1;
      else             tmo_cnt_next = tmo_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
      err_reg     <= err_next;
    end
  end

  assign err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    if_ready_next  = 1'b0;
    d_ready_next   = 1'b0;
    busy_next      = busy_reg;
    case (state_reg)
      IDLE: begin
        // Data access wins: it belongs to the instruction already fetched.
        if (d_req) begin
          state_next     = GNT_D;
          mem_req_next   = 1'b1;
          mem_we_next    = d_we;
          mem_addr_next  = d_addr;
          mem_wdata_next = d_wdata;
          busy_next      = 1'b1;
        end else if (if_req) begin
          state_next     = GNT_IF;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = if_addr;
          busy_next      = 1'b1;
        end
      end
      GNT_IF, GNT_D: begin
        if (mem_ack) begin
          state_next   = RESP;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          if (state_reg == GNT_IF) begin
            if_rdata_next = mem_rdata;
            if_ready_next = 1'b1;
          end else begin
            if (!mem_we_reg) d_rdata_next = mem_rdata;
            d_ready_next = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next   = RESP;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          if (state_reg == GNT_IF) if_ready_next = 1'b1;
          else                     d_ready_next  = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
        busy_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
      if_ready_reg  <= 1'b0;
      d_ready_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      d_rdata_reg   <= d_rdata_next;
      if_ready_reg  <= if_ready_next;
      d_ready_reg   <= d_ready_next;
      busy_reg      <= busy_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign if_ready  = if_ready_reg;
  assign d_ready   = d_ready_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scenario tasks plus a ready-pulse scoreboard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_req, mem_we, busy, err;

  mem_port_arbiter #(.AW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  logic        prev_ready = 1'b0;
  logic [135:0] all_outs;

  assign all_outs = {mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata,
                     if_ready, d_ready, busy, err};

  task automatic push_exp(input logic is_d, input logic [31:0] rdata);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] got;
    if (rst_n && (if_ready || d_ready)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stray_ready: got if_ready=%b d_ready=%b, required none", if_ready, d_ready);
      end else begin
        e   = exp_q.pop_front();
        got = e.is_d ? d_rdata : if_rdata;
        if (d_ready !== e.is_d || if_ready !== !e.is_d || got !== e.rdata) begin
          n_fail++;
          $display("FAIL ready_data: got if_ready=%b d_ready=%b rdata=%h, required %s rdata=%h",
                   if_ready, d_ready, got, e.is_d ? "d_ready" : "if_ready", e.rdata);
        end else begin
          $display("txn %s rdata=%h", e.is_d ? "data " : "fetch", got);
        end
      end
    end
    if (rst_n && prev_ready && (if_ready || d_ready)) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_width: got ready high two cycles, required one-cycle pulse");
    end
    prev_ready = rst_n && (if_ready || d_ready);
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", all_outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h, required 0", all_outs);
    end
  endtask

  task automatic test_basic_fetch();
    if_req = 1'b1; if_addr = 32'h10;
    exp_if_rdata = 32'h00500093;
    push_exp(1'b0, exp_if_rdata);
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, busy, mem_addr} !== {1'b1, 1'b0, 1'b1, 32'h10}) begin
      n_fail++;
      $display("FAIL fetch_grant: got req=%b we=%b busy=%b addr=%h, required 1 0 1 00000010",
               mem_req, mem_we, busy, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h00500093;
    @(negedge clk);
    n_checks++;
    if ({if_ready, busy, mem_req} !== 3'b110) begin
      n_fail++;
      $display("FAIL fetch_resp: got if_ready=%b busy=%b mem_req=%b, required 1 1 0",
               if_ready, busy, mem_req);
    end
    mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({if_ready, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_done: got if_ready=%b busy=%b, required 0 0", if_ready, busy);
    end
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    push_exp(1'b1, exp_d_rdata);
    exp_if_rdata = 32'hCAFE0013;
    push_exp(1'b0, exp_if_rdata);
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h40, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL store_first: got req=%b we=%b addr=%h wdata=%h, required 1 1 00000040 deadbeef",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    mem_ack = 1'b0; d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, mem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_gap: got busy=%b mem_req=%b, required 0 0", busy, mem_req);
    end
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h20}) begin
      n_fail++;
      $display("FAIL fetch_second: got req=%b we=%b addr=%h, required 1 0 00000020",
               mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE0013;
    @(negedge clk);
    mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_delay();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_wdata = 32'h55AA55AA;
    exp_d_rdata = 32'h12345678;
    push_exp(1'b1, exp_d_rdata);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_req, mem_we, mem_addr, d_ready} !== {1'b1, 1'b0, 32'h44, 1'b0}) begin
        n_fail++;
        $display("FAIL load_hold[%0d]: got req=%b we=%b addr=%h d_ready=%b, required 1 0 00000044 0",
                 i, mem_req, mem_we, mem_addr, d_ready);
      end
    end
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    n_checks++;
    if ({busy, mem_req, if_rdata, d_rdata} !== {1'b0, 1'b0, exp_if_rdata, exp_d_rdata}) begin
      n_fail++;
      $display("FAIL stray_ack: got busy=%b req=%b if_rdata=%h d_rdata=%h, required 0 0 %h %h",
               busy, mem_req, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cnt;
    if_req = 1'b1; if_addr = 32'h100;
`ifdef MEM_TIMEOUT_EN
    push_exp(1'b0, exp_if_rdata);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req) cnt++;
      else break;
    end
    n_checks++;
    if (cnt != 16 || err !== 1'b1 || if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: got req_cycles=%0d err=%b if_ready=%b, required 16 1 1",
               cnt, err, if_ready);
    end
    if_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({err, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_done: got err=%b busy=%b, required 0 0", err, busy);
    end
`else
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && err === 1'b0) cnt++;
    end
    n_checks++;
    if (cnt != 100) begin
      n_fail++;
      $display("FAIL no_timeout: got %0d of 100 cycles with mem_req=1 err=0, required 100", cnt);
    end
    if_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_grant: got mem_req=%b, required 1", mem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: got mem_req=%b busy=%b, required 0 0", mem_req, busy);
    end
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++;
      $display("FAIL after_mid_reset: got %h, required 0", all_outs);
    end
  endtask

  initial begin
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_basic_fetch();
    test_priority();
    test_load_delay();
    test_stray_ack();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_ready: got %0d outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100us, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
